// File: rtl/csa_pkg.sv
// Shared constants and elaboration-time parameter checks for the carry-select adder.
package csa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // True when the width splits evenly into stages made of whole blocks.
    function automatic bit params_ok(
        input int unsigned width,
        input int unsigned block,
        input int unsigned stages
    );
        if (stages < 1 || block < 1 || width < 1) begin
            return 1'b0;
        end
        return (width % (block * stages)) == 0;
    endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder.
interface pipelined_carry_select_adder_if #(
    parameter int unsigned WIDTH = 64
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, in1, in2, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, in1, in2, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/csa_select_block.sv
// One carry-select block: two ripple adders (carry-in 0 and 1) and a select mux.
module csa_select_block #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK-1:0] w_s0;
    logic [BLOCK-1:0] w_s1;
    logic             w_c0;
    logic             w_c1;

    // Ripple both speculative sums; the chains are independent of cin.
    always_comb begin
        w_s0 = '0;
        w_s1 = '0;
        w_c0 = 1'b0;
        w_c1 = 1'b1;
        for (int i = 0; i < int'(BLOCK); i++) begin
            w_s0[i] = a[i] ^ b[i] ^ w_c0;
            w_c0    = (a[i] & b[i]) | (w_c0 & (a[i] ^ b[i]));
            w_s1[i] = a[i] ^ b[i] ^ w_c1;
            w_c1    = (a[i] & b[i]) | (w_c1 & (a[i] ^ b[i]));
        end
    end

    assign s    = cin ? w_s1 : w_s0;
    assign cout = w_c0 | (w_c1 & cin);

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Streaming carry-select adder/subtractor; each stage resolves WIDTH/STAGES bits.
module pipelined_carry_select_adder #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    pipelined_carry_select_adder_if.slave bus
);

    import csa_pkg::*;

    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NB = SW / BLOCK;

    if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_params
        $error("pipelined_carry_select_adder: WIDTH must be a multiple of BLOCK*STAGES");
    end

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Subtract becomes A + ~B + 1, so the datapath only ever adds.
    assign w_b_eff   = (bus.sub == OP_SUB) ? ~bus.in2 : bus.in2;
    assign w_cin_eff = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned IN_W = WIDTH - s * SW;
        localparam int unsigned DONE = (s + 1) * SW;

        logic            w_ready;
        logic            w_in_valid;
        logic [IN_W-1:0] w_a;
        logic [IN_W-1:0] w_b;
        logic            w_cin;
        logic            w_cout;
        logic [SW-1:0]   w_chunk;
        logic [DONE-1:0] w_sum_next;

        logic            r_valid;
        logic            r_carry;
        logic [DONE-1:0] r_sum;

        if (s == STAGES - 1) begin : g_rdy
            assign w_ready = ~r_valid | bus.out_ready;
        end else begin : g_rdy
            assign w_ready = ~r_valid | g_stage[s+1].w_ready;
        end

        if (s == 0) begin : g_src
            assign w_in_valid = bus.in_valid;
            assign w_a        = bus.in1;
            assign w_b        = w_b_eff;
            assign w_cin      = w_cin_eff;
            assign w_sum_next = w_chunk;
        end else begin : g_src
            assign w_in_valid = g_stage[s-1].r_valid;
            assign w_a        = g_stage[s-1].g_fwd.r_a;
            assign w_b        = g_stage[s-1].g_fwd.r_b;
            assign w_cin      = g_stage[s-1].r_carry;
            assign w_sum_next = {w_chunk, g_stage[s-1].r_sum};
        end

        for (genvar k = 0; k < NB; k++) begin : g_blk
            logic w_bcin;
            logic w_bcout;

            if (k == 0) begin : g_cin
                assign w_bcin = w_cin;
            end else begin : g_cin
                assign w_bcin = g_blk[k-1].w_bcout;
            end

            csa_select_block #(
                .BLOCK (BLOCK)
            ) u_blk (
                .a    (w_a[k*BLOCK +: BLOCK]),
                .b    (w_b[k*BLOCK +: BLOCK]),
                .cin  (w_bcin),
                .s    (w_chunk[k*BLOCK +: BLOCK]),
                .cout (w_bcout)
            );
        end

        assign w_cout = g_blk[NB-1].w_bcout;

        // Stage slot advances when empty or when its occupant moves on this edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_ready) begin
                r_valid <= w_in_valid;
                r_carry <= w_cout;
                r_sum   <= w_sum_next;
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            localparam int unsigned REM = IN_W - SW;

            logic [REM-1:0] r_a;
            logic [REM-1:0] r_b;

            // Carry only the operand bits later stages still need.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_ready) begin
                    r_a <= w_a[IN_W-1:SW];
                    r_b <= w_b[IN_W-1:SW];
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Signed overflow from the sign bits of A, effective B and the sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_ready) begin
                    r_ovf <= (w_a[SW-1] == w_b[SW-1]) && (w_chunk[SW-1] != w_a[SW-1]);
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].w_ready & ~rst;
    assign bus.out_valid = g_stage[STAGES-1].r_valid;
    assign bus.sum       = g_stage[STAGES-1].r_sum;
    assign bus.cout      = g_stage[STAGES-1].r_carry;
    assign bus.ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Scoreboard bench for the pipelined carry-select adder (64/4/4 and 16/4/2 instances).
module tb_pipelined_carry_select_adder;

    localparam int unsigned LAT64 = 4;
    localparam int unsigned LAT16 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int n_cmp = 0;

    pipelined_carry_select_adder_if #(.WIDTH(64)) bus64 ();
    pipelined_carry_select_adder_if #(.WIDTH(16)) bus16 ();

    pipelined_carry_select_adder #(.WIDTH(64), .BLOCK(4), .STAGES(4)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4), .STAGES(2)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t sb64[$];
    exp_t sb16[$];
    bit   lat_chk64 = 1'b0;
    bit   lat_chk16 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare on every output transfer, check hold under stall.
    exp_t        e64;
    logic [65:0] hold64;
    bit          holding64 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            holding64 = 1'b0;
        end else if (bus64.out_valid) begin
            if (holding64) chk("hold64", {62'd0, bus64.ovf, bus64.cout} ^ 64'(hold64[65:64]) | (bus64.sum ^ hold64[63:0]), 64'd0);
            if (bus64.out_ready) begin
                holding64 = 1'b0;
                n_cmp++;
                if (sb64.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected64: got sum %0h with empty scoreboard (cycle %0d)", bus64.sum, cyc);
                end else begin
                    e64 = sb64.pop_front();
                    chk("sum64", bus64.sum, e64.sum);
                    chk("cout64", 64'(bus64.cout), 64'(e64.cout));
                    chk("ovf64", 64'(bus64.ovf), 64'(e64.ovf));
                    if (e64.chk_lat) chk("latency64", 64'(cyc - e64.acc_cyc), 64'(LAT64));
                end
            end else begin
                holding64 = 1'b1;
                hold64    = {bus64.ovf, bus64.cout, bus64.sum};
            end
        end else begin
            holding64 = 1'b0;
        end
    end

    exp_t        e16;
    logic [17:0] hold16;
    bit          holding16 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            holding16 = 1'b0;
        end else if (bus16.out_valid) begin
            if (holding16) chk("hold16", 64'({bus16.ovf, bus16.cout, bus16.sum}), 64'(hold16));
            if (bus16.out_ready) begin
                holding16 = 1'b0;
                n_cmp++;
                if (sb16.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected16: got sum %0h with empty scoreboard (cycle %0d)", bus16.sum, cyc);
                end else begin
                    e16 = sb16.pop_front();
                    chk("sum16", 64'(bus16.sum), e16.sum);
                    chk("cout16", 64'(bus16.cout), 64'(e16.cout));
                    chk("ovf16", 64'(bus16.ovf), 64'(e16.ovf));
                    if (e16.chk_lat) chk("latency16", 64'(cyc - e16.acc_cyc), 64'(LAT16));
                end
            end else begin
                holding16 = 1'b1;
                hold16    = {bus16.ovf, bus16.cout, bus16.sum};
            end
        end else begin
            holding16 = 1'b0;
        end
    end

    // Independent arithmetic reference: {ovf, cout, sum}.
    function automatic logic [65:0] model64(input logic [63:0] a, input logic [63:0] b,
                                            input logic c, input logic s);
        logic [63:0] bb;
        logic [64:0] r;
        logic        o;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + 65'(s ? 1'b1 : c);
        o  = (a[63] == bb[63]) && (r[63] != a[63]);
        return {o, r[64], r[63:0]};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic c, input logic s);
        logic [15:0] bb;
        logic [16:0] r;
        logic        o;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + 17'(s ? 1'b1 : c);
        o  = (a[15] == bb[15]) && (r[15] != a[15]);
        return {o, r[16], r[15:0]};
    endfunction

    // Drivers run in the posedge+1 phase; in_ready is sampled at the following negedge.
    task automatic try64(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s,
                         input logic [63:0] es, input logic ec, input logic eo, output bit acc);
        exp_t x;
        bus64.in_valid = 1'b1;
        bus64.in1 = a;
        bus64.in2 = b;
        bus64.cin = c;
        bus64.sub = s;
        @(negedge clk);
        acc = bus64.in_ready;
        if (acc) begin
            x.sum = es; x.cout = ec; x.ovf = eo; x.acc_cyc = cyc; x.chk_lat = lat_chk64;
            sb64.push_back(x);
            n_vec++;
        end
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s,
                          input logic [63:0] es, input logic ec, input logic eo, output int tries);
        bit acc;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            try64(a, b, c, s, es, ec, eo, acc);
            tries++;
        end
        if (!acc) begin
            n_err++;
            $display("FAIL accept64: timed out after %0d tries", tries);
        end
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                          input logic [15:0] es, input logic ec, input logic eo, input bit rnd_ready);
        exp_t x;
        bit   acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            if (rnd_ready) bus16.out_ready = 1'($urandom_range(0, 1));
            bus16.in_valid = 1'b1;
            bus16.in1 = a;
            bus16.in2 = b;
            bus16.cin = c;
            bus16.sub = s;
            @(negedge clk);
            acc = bus16.in_ready;
            if (acc) begin
                x.sum = 64'(es); x.cout = ec; x.ovf = eo; x.acc_cyc = cyc; x.chk_lat = lat_chk16;
                sb16.push_back(x);
                n_vec++;
            end
            @(posedge clk);
            #1;
            bus16.in_valid = 1'b0;
            tries++;
        end
        if (!acc) begin
            n_err++;
            $display("FAIL accept16: timed out after %0d tries", tries);
        end
    endtask

    task automatic drain64();
        for (int i = 0; i < 64 && sb64.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain64", 64'(sb64.size()), 64'd0);
    endtask

    task automatic drain16();
        for (int i = 0; i < 64 && sb16.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain16", 64'(sb16.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [65:0] m;
        logic [17:0] m16;
        logic [15:0] a16;
        logic [15:0] b16;
        logic        c;
        logic        s;
        bit          acc;
        int          tries;
        int          stalls;
        int          accepts;
        int          idx;

        bus64.in_valid = 1'b0; bus64.in1 = '0; bus64.in2 = '0; bus64.cin = 1'b0; bus64.sub = 1'b0;
        bus64.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.in1 = '0; bus16.in2 = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        bus16.out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("in_ready64_in_reset", 64'(bus64.in_ready), 64'd0);
        chk("in_ready16_in_reset", 64'(bus16.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid64", 64'(bus64.out_valid), 64'd0);
        chk("rst_sum64", bus64.sum, 64'd0);
        chk("rst_cout64", 64'(bus64.cout), 64'd0);
        chk("rst_ovf64", 64'(bus64.ovf), 64'd0);
        chk("rst_in_ready64", 64'(bus64.in_ready), 64'd1);
        chk("rst_out_valid16", 64'(bus16.out_valid), 64'd0);
        chk("rst_in_ready16", 64'(bus16.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, hand-computed, latency checked.
        lat_chk64 = 1'b1;
        send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, tries);
        drain64();
        send64(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, tries);
        send64(64'd5, 64'd3, 1'b1, 1'b0, 64'd9, 1'b0, 1'b0, tries);
        send64(64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, tries);
        send64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, tries);
        send64(64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0, tries);
        send64(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, tries);
        send64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, tries);
        drain64();

        // Back-to-back random stream at full rate.
        stalls = 0;
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            m = model64(a, b, c, s);
            send64(a, b, c, s, m[63:0], m[64], m[65], tries);
            if (tries != 1) stalls++;
        end
        chk("stream_stalls64", 64'(stalls), 64'd0);
        drain64();

        // Backpressure: fill with out_ready low, then drain while accepting.
        lat_chk64 = 1'b0;
        bus64.out_ready = 1'b0;
        accepts = 0;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            try64(64'(100 + idx), 64'(idx), 1'b0, 1'b0, 64'(100 + 2 * idx), 1'b0, 1'b0, acc);
            if (acc) begin
                accepts++;
                idx++;
            end
        end
        chk("bp_accepts64", 64'(accepts), 64'd4);
        @(negedge clk);
        chk("bp_in_ready64", 64'(bus64.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus64.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready64", 64'(bus64.in_ready), 64'd1);
        @(posedge clk);
        #1;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            try64(64'(100 + idx), 64'(idx), 1'b0, 1'b0, 64'(100 + 2 * idx), 1'b0, 1'b0, acc);
            if (!acc) stalls++;
            idx++;
        end
        chk("bp_refill_stalls64", 64'(stalls), 64'd0);
        drain64();

        // Reset with three operations in flight.
        send64(64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0, tries);
        send64(64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, tries);
        send64(64'd5, 64'd6, 1'b0, 1'b0, 64'd11, 1'b0, 1'b0, tries);
        rst = 1'b1;
        sb64.delete();
        @(negedge clk);
        chk("midrst_in_ready64", 64'(bus64.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid64", 64'(bus64.out_valid), 64'd0);
        chk("midrst_in_ready64_after", 64'(bus64.in_ready), 64'd1);
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;

        // 16-bit, 2-stage instance: directed then random backpressure.
        lat_chk16 = 1'b1;
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send16(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        send16(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0);
        drain16();
        lat_chk16 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c   = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 1));
            m16 = model16(a16, b16, c, s);
            send16(a16, b16, c, s, m16[15:0], m16[16], m16[17], 1'b1);
        end
        bus16.out_ready = 1'b1;
        drain16();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
